// File: rtl/mac_pkg.sv
// Shared MAC datapath constants (common with the multiplier) and the accumulate FSM state type.
package mac_pkg;
   localparam int PROD_W_DEF  = 8;
   localparam int ACC_W_DEF   = 12;
   localparam int N_TERMS_DEF = 16;
   localparam int MUL_LAT_DEF = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;
endpackage

// File: rtl/mac_accumulator_if.sv
// Product stream in, frame result out; master drives the product side, slave is the accumulator.
interface mac_accumulator_if
   import mac_pkg::*;
#(
   parameter int PROD_W  = PROD_W_DEF,
   parameter int ACC_W   = ACC_W_DEF,
   parameter int N_TERMS = N_TERMS_DEF,
   parameter int CNT_W   = $clog2(N_TERMS + 1)
);
   logic              in_valid;
   logic [PROD_W-1:0] prod;
   logic              acc_clear;
   logic              sat_en;
   logic [ACC_W-1:0]  acc_out;
   logic              acc_valid;
   logic              acc_ovf;
   logic [CNT_W-1:0]  term_cnt;

   modport master (
      output in_valid, prod, acc_clear, sat_en,
      input  acc_out, acc_valid, acc_ovf, term_cnt
   );

   modport slave (
      input  in_valid, prod, acc_clear, sat_en,
      output acc_out, acc_valid, acc_ovf, term_cnt
   );
endinterface

// File: rtl/valid_delay_line.sv
// Depth-configurable valid shift register that tracks a fixed pipeline latency.
module valid_delay_line #(
   parameter int DEPTH = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic [DEPTH-1:0] sr;

   generate
      if (DEPTH == 1) begin : g_single
         always_ff @(posedge clk or posedge rst) begin
            if (rst) sr <= '0;
            else     sr <= d;
         end
      end else begin : g_multi
         always_ff @(posedge clk or posedge rst) begin
            if (rst) sr <= '0;
            else     sr <= {sr[DEPTH-2:0], d};
         end
      end
   endgenerate

   assign q = sr[DEPTH-1];
endmodule

// File: rtl/mac_accumulator.sv
// Accumulate stage: sums N_TERMS multiplier products per frame, optional clamp, one-cycle result pulse.
//   state | meaning
//   IDLE  | no terms accepted in the current frame (term_cnt = 0)
//   ACCUM | 0 < term_cnt < N_TERMS, partial sum held in acc_q
module mac_accumulator
   import mac_pkg::*;
#(
   parameter int PROD_W  = PROD_W_DEF,
   parameter int ACC_W   = ACC_W_DEF,
   parameter int N_TERMS = N_TERMS_DEF,
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int CNT_W   = $clog2(N_TERMS + 1)
) (
   input logic               clk,
   input logic               rst,
   mac_accumulator_if.slave  bus
);
   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] acc_out_q;
   logic             acc_valid_q, acc_ovf_q;

   logic             pvalid;
   logic             fresh;
   logic [ACC_W-1:0] base_acc;
   logic             base_ovf;
   logic [CNT_W-1:0] cnt_inc;
   logic [ACC_W:0]   sum;
   logic             carry;
   logic [ACC_W-1:0] result;
   logic             last;
   logic             done;

   valid_delay_line #(.DEPTH(MUL_LAT)) u_vdl (
      .clk (clk),
      .rst (rst),
      .d   (bus.in_valid),
      .q   (pvalid)
   );

   // A clear on the same edge as a term makes that term the first of a new frame.
   always_comb begin
      fresh    = bus.acc_clear || (state_q == IDLE);
      base_acc = fresh ? '0 : acc_q;
      base_ovf = fresh ? 1'b0 : ovf_q;
      cnt_inc  = (fresh ? '0 : cnt_q) + CNT_W'(1);
      sum      = {1'b0, base_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.prod};
      carry    = sum[ACC_W];
      result   = (carry && bus.sat_en) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
      last     = (cnt_inc == CNT_W'(N_TERMS));
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      done    = 1'b0;
      if (pvalid) begin
         if (last) begin
            state_d = IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
            done    = 1'b1;
         end else begin
            state_d = ACCUM;
            acc_d   = result;
            ovf_d   = base_ovf | carry;
            cnt_d   = cnt_inc;
         end
      end else if (bus.acc_clear) begin
         state_d = IDLE;
         acc_d   = '0;
         ovf_d   = 1'b0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         cnt_q       <= '0;
         acc_out_q   <= '0;
         acc_valid_q <= 1'b0;
         acc_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         cnt_q       <= cnt_d;
         acc_valid_q <= done;
         if (done) begin
            acc_out_q <= result;
            acc_ovf_q <= base_ovf | carry;
         end
      end
   end

   assign bus.acc_out   = acc_out_q;
   assign bus.acc_valid = acc_valid_q;
   assign bus.acc_ovf   = acc_ovf_q;
   assign bus.term_cnt  = cnt_q;
endmodule
